vga_sink: RTL
=============

VGA_SINK -- requirements
Module: vga_sink

Interface
REQ-001 SHALL have parameters H_TOTAL=800 (pclk per line), H_SYNC=96 (hsync low width), H_ACT_START=145, H_ACT_END=784 (first/last active x, 1-based).
REQ-002 SHALL have parameters V_TOTAL=525 (lines per frame), V_SYNC=2 (vsync low lines), V_ACT_START=36, V_ACT_END=515 (first/last active y, 1-based).
REQ-003 SHALL have ports: pclk in 1 pixel clock; reset in 1 synchronous active-high reset; all logic on posedge pclk.
REQ-004 SHALL have inputs hsync 1, vsync 1 (active-low sync pulses); vga_r, vga_g, vga_b 8 each, pixel colour, same clock domain, no synchroniser.
REQ-005 SHALL have outputs pix_valid 1, pix_x 10 (0..639), pix_y 10 (0..479), pix_data 24 ({r,g,b}), sof 1, eol 1.
REQ-006 SHALL have outputs locked 1, line_err 1 (pulse), frame_err 1 (pulse), frame_cnt 16.

Function
REQ-007 SHALL detect hs_fall (hsync 1 then 0), hs_rise, and vs_fall from one-cycle-delayed copies hs_prev and vs_prev.
REQ-008 SHALL form input-aligned x_in = 1 on hs_fall, else h_cnt+1 saturating at 1023; h_cnt <= x_in every cycle.
REQ-009 SHALL form y_in = 1 on vs_fall; else v_cnt+1 on hs_fall, saturating at 1023; else v_cnt. v_cnt <= y_in.
REQ-010 SHALL implement FSM IDLE -> ACQUIRE on vs_fall; ACQUIRE -> LOCKED on next vs_fall with no error since entry; any error in ACQUIRE/LOCKED -> IDLE.
REQ-011 SHALL flag a line error, outside IDLE only, when any of these holds: hs_fall with h_cnt != H_TOTAL; hs_rise with x_in != H_SYNC+1; or x_in > H_TOTAL.
REQ-012 SHALL flag a frame error, outside IDLE only, when any of these holds: vs_fall with v_cnt != V_TOTAL; vs_fall without coincident hs_fall; or vsync rising with y_in != V_SYNC+1.
REQ-013 SHALL, for each detected error, register a one-cycle line_err or frame_err pulse; a line error and a frame error detected together both pulse; the FSM enters IDLE on the next edge.
REQ-014 SHALL register outputs with one cycle latency from the sampled inputs.
REQ-015 SHALL assert pix_valid when locked and x_in is in [H_ACT_START,H_ACT_END] and y_in is in [V_ACT_START,V_ACT_END]; pix_x = x_in-H_ACT_START and pix_y = y_in-V_ACT_START, both 10-bit.
REQ-016 SHALL output pix_x=0, pix_y=0 and pix_data=0 when pix_valid is 0.
REQ-017 SHALL pulse sof with pix_valid at pix_x=0, pix_y=0, and pulse eol with pix_valid at pix_x=639.
REQ-018 SHALL register locked = (state==LOCKED), so locked lags the FSM by one cycle.
REQ-019 SHALL increment frame_cnt on every vs_fall while in LOCKED, wrapping modulo 2^16, and hold frame_cnt on loss of lock.
REQ-020 SHALL count the ACQUIRE->LOCKED transition at the vs_fall that causes it.
REQ-021 SHALL ignore all timing checks in IDLE, including the vs_fall that enters ACQUIRE.

Reset
REQ-022 SHALL, on reset, set hs_prev=0, vs_prev=0, h_cnt=0, v_cnt=0 and state=IDLE.
REQ-023 SHALL, on reset, drive all outputs to 0, including frame_cnt.
REQ-024 SHALL let reset mid-frame abort lock immediately with no err pulse.
REQ-025 SHALL require re-acquisition after reset: one full frame after the next vs_fall.

Structure
REQ-026 SHALL take the timing constants and the FSM state enum (IDLE, ACQUIRE, LOCKED) from shared package vga_pkg, which the VGA timing generator also uses.
REQ-027 SHALL instantiate one sub-module, vga_sync_edge, once per sync signal; it registers the previous sample and outputs fall and rise pulses.

Verification
REQ-028 Two clean standard frames after reset -> locked=1 from the 2nd vs_fall+1; frame_cnt=1; sof at the first active pixel of the 3rd frame; 640x480 pix_valid per frame.
REQ-029 Pixel colour 0x123456 at x=145, y=36 -> pix_valid=1, pix_x=0, pix_y=0, pix_data=0x123456 and sof=1 one cycle later.
REQ-030 While locked, one line 799 clocks long -> line_err pulses once; locked drops; 0 pix_valid until relock two frames later.
REQ-031 While locked, a frame of 524 lines -> frame_err pulse at vs_fall; locked=0; frame_cnt held.
REQ-032 While locked, hsync held high beyond 800 clocks -> line_err at x_in=801; state IDLE.
REQ-033 Reset asserted at line 200 while locked -> all outputs 0 next cycle; no err pulse; relock after two vs_fall.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and FSM state encoding, used by both the
// timing generator and the sink.
package vga_pkg;

  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_ACT_START = 145;
  localparam int VGA_H_ACT_END   = 784;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_ACT_START = 36;
  localparam int VGA_V_ACT_END   = 515;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } vga_state_e;

  // Position counters stick at all-ones so a runaway sync cannot wrap back
  // into the active window.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers the previous sample of one sync line and flags its falling and
// rising edges against the current sample.
module vga_sync_edge (
  input  logic pclk,
  input  logic reset,
  input  logic sync_in,
  output logic fall,
  output logic rise
);

  logic prev;

  always_ff @(posedge pclk) begin
    if (reset) prev <= 1'b0;
    else       prev <= sync_in;
  end

  assign fall = prev & ~sync_in;
  assign rise = ~prev & sync_in;

endmodule

// File: rtl/vga_sink.sv
// VGA capture: recovers pixel position from hsync/vsync, checks line and
// frame timing, and emits valid pixels with sof/eol once locked.
module vga_sink
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_ACT_START = VGA_H_ACT_START,
  parameter int H_ACT_END   = VGA_H_ACT_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_ACT_START = VGA_V_ACT_START,
  parameter int V_ACT_END   = VGA_V_ACT_END
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_data,
  output logic        sof,
  output logic        eol,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam logic [CNT_W-1:0] HT   = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] HS1  = CNT_W'(H_SYNC + 1);
  localparam logic [CNT_W-1:0] HAS  = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0] HAE  = CNT_W'(H_ACT_END);
  localparam logic [CNT_W-1:0] VT   = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] VS1  = CNT_W'(V_SYNC + 1);
  localparam logic [CNT_W-1:0] VAS  = CNT_W'(V_ACT_START);
  localparam logic [CNT_W-1:0] VAE  = CNT_W'(V_ACT_END);

  // bit 0: hsync, bit 1: vsync
  logic [1:0] sync_bus, fall, rise;
  assign sync_bus = {vsync, hsync};

  for (genvar i = 0; i < 2; i++) begin : g_edge
    vga_sync_edge u_edge (
      .pclk    (pclk),
      .reset   (reset),
      .sync_in (sync_bus[i]),
      .fall    (fall[i]),
      .rise    (rise[i])
    );
  end

  logic hs_fall, hs_rise, vs_fall, vs_rise;
  assign hs_fall = fall[0];
  assign hs_rise = rise[0];
  assign vs_fall = fall[1];
  assign vs_rise = rise[1];

  logic [CNT_W-1:0] h_cnt, v_cnt, x_in, y_in;

  // x_in/y_in are the 1-based coordinates of the sample on the inputs now.
  always_comb begin
    x_in = hs_fall ? CNT_W'(1) : sat_inc(h_cnt);
    y_in = v_cnt;
    if (vs_fall)      y_in = CNT_W'(1);
    else if (hs_fall) y_in = sat_inc(v_cnt);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= x_in;
      v_cnt <= y_in;
    end
  end

  vga_state_e state, state_d;
  logic line_hit, frame_hit, line_bad, frame_bad, cnt_inc, pv;

  assign line_hit  = (hs_fall && h_cnt != HT) || (hs_rise && x_in != HS1) || (x_in > HT);
  assign frame_hit = (vs_fall && (v_cnt != VT || !hs_fall)) || (vs_rise && y_in != VS1);
  assign line_bad  = (state != IDLE) && line_hit;
  assign frame_bad = (state != IDLE) && frame_hit;

  always_ff @(posedge pclk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (vs_fall) state_d = ACQUIRE;
      ACQUIRE: if (line_bad || frame_bad) state_d = IDLE;
               else if (vs_fall)          state_d = LOCKED;
      LOCKED:  if (line_bad || frame_bad) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every error-free vs_fall that leaves us in LOCKED is a counted frame,
  // including the one that completes acquisition.
  assign cnt_inc = vs_fall && (state_d == LOCKED);

  assign pv = (state == LOCKED) && (x_in >= HAS) && (x_in <= HAE)
                                && (y_in >= VAS) && (y_in <= VAE);

  always_ff @(posedge pclk) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      locked    <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      pix_valid <= pv;
      pix_x     <= pv ? x_in - HAS : '0;
      pix_y     <= pv ? y_in - VAS : '0;
      pix_data  <= pv ? {vga_r, vga_g, vga_b} : '0;
      sof       <= pv && (x_in == HAS) && (y_in == VAS);
      eol       <= pv && (x_in == HAE);
      locked    <= (state == LOCKED);
      line_err  <= line_bad;
      frame_err <= frame_bad;
      frame_cnt <= frame_cnt + (cnt_inc ? 16'd1 : 16'd0);
    end
  end

endmodule
